// File: rtl/div_unit_pkg.sv
// Shared types and op encodings for the RV32M iterative divider.
// Decodes the ALU function field into divider controls.
package div_unit_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int CNT_W_DEF = 6;

  localparam logic [4:0] ALUFN_DIV  = 5'b10100;
  localparam logic [4:0] ALUFN_DIVU = 5'b10101;
  localparam logic [4:0] ALUFN_REM  = 5'b10110;
  localparam logic [4:0] ALUFN_REMU = 5'b10111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic is_rem;
    logic is_signed;
  } op_t;

  // All four divide codes share the 101xx prefix.
  function automatic logic is_div_op(input logic [4:0] fn);
    return fn[4:2] == 3'b101;
  endfunction

  function automatic op_t decode_op(input logic [4:0] fn);
    op_t op;
    op.is_rem    = fn[1];
    op.is_signed = ~fn[0];
    return op;
  endfunction

endpackage

// File: rtl/div_unit_if.sv
// EX-stage handshake between the pipeline control and the divider.
// master = pipeline side, slave = divider.
interface div_unit_if #(parameter int XLEN = 32);
  logic            start;
  logic [4:0]      alufn;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            flush;
  logic            stall;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (output start, alufn, a, b, flush,
                  input  stall, done, result);
  modport slave  (input  start, alufn, a, b, flush,
                  output stall, done, result);
endinterface

// File: rtl/div_unit.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU: one quotient bit per cycle,
// signed ops run on magnitudes with a sign fixup folded into the final step.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input logic       clk,
  input logic       rst,
  div_unit_if.slave bus
);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [XLEN-1:0]   rem_q, quo_q, dvs_q, result_q;
  logic              rem_op_q, neg_quo_q, neg_rem_q;

  logic              accept_window, valid_op, accept, last_step;
  logic              div0, ovf, special;
  op_t               op_in;
  logic [XLEN-1:0]   rem_n, quo_n, q_fix, r_fix, fin_result, sp_result;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic sgn);
    return (sgn && v[XLEN-1]) ? -v : v;
  endfunction

  // One restoring step on {rem, quo}; the shifted remainder needs one extra bit.
  function automatic logic [2*XLEN-1:0] div_step(input logic [XLEN-1:0] rem,
                                                 input logic [XLEN-1:0] quo,
                                                 input logic [XLEN-1:0] dvs);
    logic [XLEN:0] sh;
    logic [XLEN:0] diff;
    sh   = {rem, quo[XLEN-1]};
    diff = sh - {1'b0, dvs};
    if (diff[XLEN]) return {sh[XLEN-1:0], quo[XLEN-2:0], 1'b0};
    else            return {diff[XLEN-1:0], quo[XLEN-2:0], 1'b1};
  endfunction

  assign accept_window = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign valid_op      = bus.start && is_div_op(bus.alufn);
  assign op_in         = decode_op(bus.alufn);
  assign div0          = (bus.b == '0);
  assign ovf           = op_in.is_signed && (bus.a == INT_MIN) && (bus.b == '1);
  assign special       = div0 || ovf;
  assign accept        = accept_window && valid_op && !bus.flush;
  assign last_step     = (cnt_q == CNT_W'(XLEN-1));

  assign {rem_n, quo_n} = div_step(rem_q, quo_q, dvs_q);
  assign q_fix          = neg_quo_q ? -quo_n : quo_n;
  assign r_fix          = neg_rem_q ? -rem_n : rem_n;
  assign fin_result     = rem_op_q ? r_fix : q_fix;
  assign sp_result      = div0 ? (op_in.is_rem ? bus.a : '1)
                               : (op_in.is_rem ? '0 : INT_MIN);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would chain updates within one edge.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept)                  state_d = special ? ST_DONE : ST_CALC;
        else if (state_q == ST_DONE) state_d = ST_IDLE;
      end
      ST_CALC:  if (last_step) state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
    if (bus.flush) state_d = ST_IDLE;
  end

  // NOTE: every datapath register is reset, including the iteration
  // registers, so a reset mid-division leaves no stale partial result.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      result_q  <= '0;
      rem_op_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else if (bus.flush) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q     <= '0;
      rem_op_q  <= op_in.is_rem;
      neg_quo_q <= op_in.is_signed && (bus.a[XLEN-1] ^ bus.b[XLEN-1]);
      neg_rem_q <= op_in.is_signed && bus.a[XLEN-1];
      if (special) begin
        result_q <= sp_result;
      end else begin
        rem_q <= '0;
        quo_q <= mag(bus.a, op_in.is_signed);
        dvs_q <= mag(bus.b, op_in.is_signed);
      end
    end else if (state_q == ST_CALC) begin
      rem_q <= rem_n;
      quo_q <= quo_n;
      if (last_step) begin
        cnt_q    <= '0;
        result_q <= fin_result;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign bus.stall  = (state_q == ST_CALC) || (accept_window && valid_op && !special);
  assign bus.done   = (state_q == ST_DONE);
  assign bus.result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: vector table for op/latency/result, plus
// hand-written flush, back-to-back, invalid-op and mid-division reset sequences.
module tb_div_unit;
  import div_unit_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  logic [31:0] last_result = '0;

  div_unit_if #(.XLEN(32)) bus ();

  div_unit #(.XLEN(32), .CNT_W(6)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [4:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Launch one op in the current cycle and follow it to its done pulse.
  task automatic run_op(input string name, input logic [4:0] fn, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    int cyc;
    bit seen;
    bit stall_ok;
    bus.alufn = fn; bus.a = a; bus.b = b; bus.start = 1'b1;
    #1;
    check({name, " stall@0"}, 32'(bus.stall), 32'(lat > 1));
    seen = 0; stall_ok = 1;
    for (cyc = 1; cyc <= 100; cyc++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      #1;
      if (bus.done) begin seen = 1; break; end
      if (!bus.stall) stall_ok = 0;
      if (cyc == 1) check({name, " result held mid-op"}, bus.result, last_result);
    end
    check({name, " latency"}, seen ? 32'(cyc) : 32'hFFFF_FFFF, 32'(lat));
    check({name, " result"}, bus.result, exp);
    check({name, " stall while busy"}, 32'(stall_ok), 32'd1);
    check({name, " stall in done cycle"}, 32'(bus.stall), 32'd0);
    step();
    check({name, " done one cycle"}, 32'(bus.done), 32'd0);
    last_result = exp;
  endtask

  initial begin
    int n_done;
    int cyc;
    bit seen;

    vecs[0]  = '{"DIV -7/2",        ALUFN_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33};
    vecs[1]  = '{"REM -7/2",        ALUFN_REM,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33};
    vecs[2]  = '{"DIVU 100/7",      ALUFN_DIVU, 32'd100,       32'd7,         32'd14,        33};
    vecs[3]  = '{"REMU 100/7",      ALUFN_REMU, 32'd100,       32'd7,         32'd2,         33};
    vecs[4]  = '{"DIVU max/1",      ALUFN_DIVU, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 33};
    vecs[5]  = '{"DIV 5/0",         ALUFN_DIV,  32'd5,         32'd0,         32'hFFFF_FFFF, 1};
    vecs[6]  = '{"REMU 5/0",        ALUFN_REMU, 32'd5,         32'd0,         32'd5,         1};
    vecs[7]  = '{"DIV ovf",         ALUFN_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
    vecs[8]  = '{"REM ovf",         ALUFN_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1};
    vecs[9]  = '{"DIV 7/-2",        ALUFN_DIV,  32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33};
    vecs[10] = '{"REM 7/-2",        ALUFN_REM,  32'd7,         32'hFFFF_FFFE, 32'd1,         33};
    vecs[11] = '{"DIV -8/-2",       ALUFN_DIV,  32'hFFFF_FFF8, 32'hFFFF_FFFE, 32'd4,         33};
    vecs[12] = '{"REM min/3",       ALUFN_REM,  32'h8000_0000, 32'd3,         32'hFFFF_FFFE, 33};
    vecs[13] = '{"DIVU 2^31/3",     ALUFN_DIVU, 32'h8000_0000, 32'd3,         32'h2AAA_AAAA, 33};
    vecs[14] = '{"REM -7/0",        ALUFN_REM,  32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 1};
    vecs[15] = '{"DIV min/1",       ALUFN_DIV,  32'h8000_0000, 32'd1,         32'h8000_0000, 33};

    bus.start = 1'b0; bus.flush = 1'b0; bus.alufn = '0; bus.a = '0; bus.b = '0;
    repeat (3) step();
    rst = 1'b0;
    #1;
    check("reset done", 32'(bus.done), 32'd0);
    check("reset result", bus.result, 32'd0);
    check("reset stall", 32'(bus.stall), 32'd0);
    step();

    foreach (vecs[i]) run_op(vecs[i].name, vecs[i].fn, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

    // Non-divide alufn with start must be ignored.
    bus.alufn = 5'b00000; bus.a = 32'd100; bus.b = 32'd7; bus.start = 1'b1;
    #1;
    check("invalid op stall", 32'(bus.stall), 32'd0);
    n_done = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (i == 2) bus.start = 1'b0;
      if (bus.done) n_done++;
    end
    check("invalid op no done", 32'(n_done), 32'd0);
    check("invalid op result", bus.result, last_result);

    // Flush in cycle 10 of a normal op.
    bus.alufn = ALUFN_DIVU; bus.a = 32'd100; bus.b = 32'd7; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (9) step();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    #1;
    check("flush stall", 32'(bus.stall), 32'd0);
    check("flush done", 32'(bus.done), 32'd0);
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.done) n_done++;
    end
    check("flush no done", 32'(n_done), 32'd0);
    check("flush result held", bus.result, last_result);
    run_op("REMU 9/4 after flush", ALUFN_REMU, 32'd9, 32'd4, 32'd1, 33);

    // Back-to-back: new op presented in the DONE cycle.
    bus.alufn = ALUFN_DIVU; bus.a = 32'd100; bus.b = 32'd7; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (bus.done) begin seen = 1; break; end
      step();
    end
    check("b2b first done seen", 32'(seen), 32'd1);
    bus.alufn = ALUFN_REMU; bus.start = 1'b1;
    #1;
    check("b2b first result", bus.result, 32'd14);
    check("b2b stall in done", 32'(bus.stall), 32'd1);
    seen = 0;
    for (cyc = 1; cyc <= 100; cyc++) begin
      step();
      bus.start = 1'b0;
      #1;
      if (bus.done) begin seen = 1; break; end
    end
    check("b2b second latency", seen ? 32'(cyc) : 32'hFFFF_FFFF, 32'd33);
    check("b2b second result", bus.result, 32'd2);
    step();

    // Reset in the middle of a division.
    bus.alufn = ALUFN_DIVU; bus.a = 32'd100; bus.b = 32'd7; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (5) step();
    rst = 1'b1;
    step();
    #1;
    check("mid rst done", 32'(bus.done), 32'd0);
    check("mid rst result", bus.result, 32'd0);
    check("mid rst stall", 32'(bus.stall), 32'd0);
    rst = 1'b0;
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.done) n_done++;
    end
    check("mid rst no done", 32'(n_done), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
